// File: rtl/fir_pkg.sv
// Shared widths, fixed-point coefficients and state encoding for the
// heart-rate FIR sequencer and its sample ring.
package fir_pkg;
    localparam int DATA_W = 10;
    localparam int NTAPS  = 31;
    localparam int NPAIR  = (NTAPS + 1) / 2;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 32;
    localparam int PTR_W  = 5;
    localparam int K_W    = 4;
    localparam int FRAC_W = 15;

    localparam logic [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRAC_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // Unsigned Q0.15 half of the symmetric impulse response, outermost tap first.
    localparam logic [COEF_W-1:0] COEF [0:NPAIR-1] = '{
        16'd105,  16'd128,  16'd180,  16'd265,  16'd390,  16'd544,  16'd727,  16'd934,
        16'd1150, 16'd1373, 16'd1586, 16'd1776, 16'd1940, 16'd2064, 16'd2140, 16'd2166
    };

    function automatic logic [PTR_W-1:0] ring_idx(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W-1:0] off);
        logic [PTR_W:0] d;
        d = {1'b0, base} - {1'b0, off};
        if (d[PTR_W]) d = d + (PTR_W+1)'(NTAPS);
        return d[PTR_W-1:0];
    endfunction
endpackage

// File: rtl/fir_sample_ring.sv
// 31-entry circular sample history; reads are addressed as an offset back
// from the newest entry so the sequencer never handles the wrap itself.
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]  i_off_a,
    input  logic [PTR_W-1:0]  i_off_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);
    logic [DATA_W-1:0] r_mem [0:NTAPS-1];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  w_newest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[r_wp] <= i_wr_data;
            r_wp        <= (r_wp == PTR_W'(NTAPS - 1)) ? '0 : r_wp + 1'b1;
        end
    end

    assign w_newest = ring_idx(r_wp, PTR_W'(1));
    assign o_rd_a   = r_mem[ring_idx(w_newest, i_off_a)];
    assign o_rd_b   = r_mem[ring_idx(w_newest, i_off_b)];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed symmetric FIR: one shared pre-add/multiply/accumulate step
// per coefficient pair, then round, saturate and publish one sample.
//  state | meaning
//  IDLE  | waiting for a sample, sample_ready high
//  MAC   | accumulate pair r_k (centre tap alone when r_k = NPAIR-1)
//  ROUND | round half-up, saturate, register filt_out
//  OUT   | one-cycle filt_valid pulse
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W-1:0] filt_out,
    output logic              filt_valid,
    output logic              primed,
    output logic              overrun,
    input  logic              clear_overrun
);
    localparam int PROD_W  = DATA_W + 1 + COEF_W;
    localparam int SHIFT_W = ACC_W + 1 - FRAC_W;
    localparam logic [DATA_W-1:0] DATA_MAX = '1;

    logic [1:0]         r_state;
    logic [K_W-1:0]     r_k;
    logic [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_filt;
    logic               r_overrun;
    logic [PTR_W-1:0]   r_cnt;

    logic               w_ready;
    logic               w_accept;
    logic               w_drop;
    logic               w_centre;
    logic [DATA_W-1:0]  w_rd_a;
    logic [DATA_W-1:0]  w_rd_b;
    logic [DATA_W:0]    w_preadd;
    logic [PROD_W-1:0]  w_prod;
    logic [SHIFT_W-1:0] w_shift;
    logic [DATA_W-1:0]  w_sat;

    // Gated with reset so the front end never sees ready while held in reset.
    assign w_ready  = reset & (r_state == IDLE);
    assign w_accept = sample_valid & w_ready;
    assign w_drop   = sample_valid & ~w_ready;

    fir_sample_ring u_ring (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_accept),
        .i_wr_data (sample_in),
        .i_off_a   ({1'b0, r_k}),
        .i_off_b   (PTR_W'(NTAPS - 1) - {1'b0, r_k}),
        .o_rd_a    (w_rd_a),
        .o_rd_b    (w_rd_b)
    );

    assign w_centre = (r_k == K_W'(NPAIR - 1));
    assign w_preadd = w_centre ? {1'b0, w_rd_a} : ({1'b0, w_rd_a} + {1'b0, w_rd_b});
    assign w_prod   = PROD_W'(w_preadd) * PROD_W'(COEF[r_k]);

    // One extra bit keeps the rounding add from wrapping near full-scale acc.
    assign w_shift  = SHIFT_W'(({1'b0, r_acc} + {1'b0, ROUND_C}) >> FRAC_W);
    assign w_sat    = (w_shift > SHIFT_W'(DATA_MAX)) ? DATA_MAX : w_shift[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_acc   <= '0;
            r_filt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (w_centre) r_state <= ROUND;
                    else          r_k     <= r_k + 1'b1;
                end
                ROUND: begin
                    r_filt  <= w_sat;
                    r_state <= OUT;
                end
                OUT:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_drop)             r_overrun <= 1'b1;
            else if (clear_overrun) r_overrun <= 1'b0;
            if (w_accept && !primed) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sample_ready = w_ready;
    assign filt_out     = r_filt;
    assign filt_valid   = (r_state == OUT);
    assign primed       = (r_cnt == PTR_W'(NTAPS));
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: an arrival-order history model
// predicts every filtered sample and its latency.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [9:0] filt_out;
    logic       filt_valid;
    logic       primed;
    logic       overrun;
    logic       clear_overrun = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int hist_q[$];
    int exp_q[$];
    int edge_q[$];

    localparam int C [0:15] = '{105, 128, 180, 265, 390, 544, 727, 934,
                                1150, 1373, 1586, 1776, 1940, 2064, 2140, 2166};

    fir_mac_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .filt_out      (filt_out),
        .filt_valid    (filt_valid),
        .primed        (primed),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int hx(input int j);
        if (j < hist_q.size()) return hist_q[hist_q.size() - 1 - j];
        return 0;
    endfunction

    function automatic int model_out();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 15; k++) acc += longint'(C[k]) * longint'(hx(k) + hx(30 - k));
        acc += longint'(C[15]) * longint'(hx(15));
        r = (acc + 16384) >>> 15;
        if (r > 1023) r = 1023;
        return int'(r);
    endfunction

    // Called at the negedge just before the accepting posedge.
    task automatic model_accept(input int v);
        hist_q.push_back(v);
        exp_q.push_back(model_out());
        edge_q.push_back(cyc + 1);
    endtask

    always @(negedge clk) begin
        int e;
        int a;
        if (reset && filt_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", int'(filt_valid), 0);
            end else begin
                e = exp_q.pop_front();
                a = edge_q.pop_front();
                chk("filt_out", int'(filt_out), e);
                chk("latency", cyc + 1 - a, 18);
            end
        end
    end

    task automatic send(input int v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!sample_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", int'(sample_ready), 1);
        sample_in    = 10'(v);
        sample_valid = 1'b1;
        model_accept(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        sample_valid  = 1'b0;
        clear_overrun = 1'b0;
        hist_q.delete();
        exp_q.delete();
        edge_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_filt_out", int'(filt_out), 0);
        chk("rst_filt_valid", int'(filt_valid), 0);
        chk("rst_primed", int'(primed), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(sample_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int last;
        int val;
        int vcount;

        do_reset();

        // Impulse response
        send(1000);
        for (int i = 0; i < 30; i++) send(0);
        drain();
        chk("impulse_primed", int'(primed), 1);

        // DC level and primed threshold
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(512);
            if (i == 29) chk("primed_30", int'(primed), 0);
            if (i == 30) chk("primed_31", int'(primed), 1);
        end
        drain();
        chk("dc_level", int'(filt_out), 512);

        // Full scale, then overridden accumulator to exercise the clamp
        for (int i = 0; i < 35; i++) send(1023);
        drain();
        chk("full_scale", int'(filt_out), 1023);
        send(1023);
        repeat (16) @(negedge clk);
        force dut.r_acc = 32'h7FFF_FFFF;
        @(negedge clk);
        release dut.r_acc;
        drain();
        chk("saturate", int'(filt_out), 1023);

        // Back-to-back offers
        chk("overrun_idle", int'(overrun), 0);
        n_acc = 0;
        last  = -1;
        val   = 3;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 2)  chk("overrun_set", int'(overrun), 1);
            if (i == 26) chk("overrun_set_wins", int'(overrun), 1);
            sample_in     = 10'(val);
            sample_valid  = 1'b1;
            clear_overrun = (i == 25);
            if (sample_ready) begin
                if (last >= 0) chk("accept_spacing", cyc - last, 19);
                last = cyc;
                model_accept(val);
                n_acc++;
            end
            val = (val + 37) % 1024;
        end
        @(negedge clk);
        sample_valid  = 1'b0;
        clear_overrun = 1'b0;
        chk("accept_count", n_acc, 4);
        drain();
        chk("overrun_sticky", int'(overrun), 1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        @(negedge clk);
        chk("overrun_clear", int'(overrun), 0);

        // Abort mid-MAC
        for (int i = 0; i < 5; i++) send(700 + i);
        drain();
        send(900);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        hist_q.delete();
        exp_q.delete();
        edge_q.delete();
        @(negedge clk);
        chk("abort_filt_out", int'(filt_out), 0);
        chk("abort_primed", int'(primed), 0);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (filt_valid) vcount++;
        end
        chk("abort_no_valid", vcount, 0);
        send(1000);
        drain();
        chk("post_abort_impulse", int'(filt_out), 3);
        for (int i = 0; i < 20; i++) send(0);
        drain();

        // Ramp through several pointer wraps
        for (int i = 1; i <= 100; i++) send(i);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
